// File: rtl/axi_burst_write_master.sv
// AXI write master: streams a block of beats out as INCR bursts.
// Bursts are capped at MAX_BURST beats and never cross a 4 KB page.
module axi_burst_write_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  MC_WREQ,
    input  logic [ADDR_WIDTH-1:0] MC_WADDR,
    input  logic [CNT_WIDTH-1:0]  MC_WBEATS,
    input  logic [DATA_WIDTH-1:0] MC_WDATA,
    input  logic                  MC_WDVALID,
    output logic                  MC_WDREADY,
    output logic                  MC_BUSY,
    output logic                  MC_WDONE,
    output logic                  MC_WERROR,
    output logic [ADDR_WIDTH-1:0] AW_ADDR,
    output logic [7:0]            AW_LEN,
    output logic [2:0]            AW_SIZE,
    output logic [1:0]            AW_BURST,
    output logic                  AW_VALID,
    input  logic                  AW_READY,
    output logic [DATA_WIDTH-1:0] W_DATA,
    output logic                  W_LAST,
    output logic                  W_VALID,
    input  logic                  W_READY,
    input  logic [1:0]            B_RESP,
    input  logic                  B_VALID,
    output logic                  B_READY
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SZ    = $clog2(BYTES);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AW   = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_RESP = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CNT_WIDTH-1:0]  remaining;
    logic [8:0]            len;
    logic [8:0]            beat_cnt;
    logic                  aw_valid;
    logic                  w_last;
    logic                  b_ready;
    logic                  busy;
    logic                  wdone;
    logic                  werror;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]            aw_len;

    logic                  in_data;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  b_hs;
    logic [ADDR_WIDTH-1:0] cand_addr;
    logic [CNT_WIDTH-1:0]  cand_rem;
    logic [12:0]           to_bound;
    logic [12:0]           bnd_beats;
    logic [12:0]           cap_beats;
    logic [8:0]            cand_len;
    logic                  unused_bits;

    assign in_data     = (state == S_DATA);
    assign W_VALID     = in_data & MC_WDVALID;
    assign MC_WDREADY  = in_data & W_READY;
    assign W_DATA      = MC_WDATA;
    assign w_hs        = W_VALID & W_READY;
    assign aw_hs       = aw_valid & AW_READY;
    assign b_hs        = B_VALID & b_ready;
    assign AW_SIZE     = 3'(SZ);
    assign AW_BURST    = 2'b01;
    assign AW_VALID    = aw_valid;
    assign AW_ADDR     = aw_addr;
    assign AW_LEN      = aw_len;
    assign W_LAST      = w_last;
    assign B_READY     = b_ready;
    assign MC_BUSY     = busy;
    assign MC_WDONE    = wdone;
    assign MC_WERROR   = werror;
    assign unused_bits = B_RESP[0];

    // Address/remaining/length of the burst about to be announced on AW
    always_comb begin
        cand_addr = MC_WADDR & ALIGN_MASK;
        cand_rem  = MC_WBEATS;
        if (state == S_RESP) begin
            cand_addr = addr + (ADDR_WIDTH'(len) << SZ);
            cand_rem  = remaining - CNT_WIDTH'(len);
        end
        to_bound  = 13'h1000 - {1'b0, cand_addr[11:0]};
        bnd_beats = to_bound >> SZ;
        cap_beats = (bnd_beats < 13'(MAX_BURST)) ? bnd_beats
                                                 : 13'(MAX_BURST);
        cand_len  = (cand_rem < CNT_WIDTH'(cap_beats)) ? 9'(cand_rem)
                                                       : cap_beats[8:0];
    end

    // Transfer sequencer: request -> AW -> W beats -> B -> next burst or done
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= S_IDLE;
            addr      <= '0;
            remaining <= '0;
            len       <= '0;
            beat_cnt  <= '0;
            aw_valid  <= 1'b0;
            w_last    <= 1'b0;
            b_ready   <= 1'b0;
            busy      <= 1'b0;
            wdone     <= 1'b0;
            werror    <= 1'b0;
            aw_addr   <= '0;
            aw_len    <= '0;
        end else begin
            wdone <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (MC_WREQ) begin
                        werror <= 1'b0;
                        if (MC_WBEATS == '0) begin
                            wdone <= 1'b1;
                        end else begin
                            busy      <= 1'b1;
                            addr      <= cand_addr;
                            remaining <= cand_rem;
                            len       <= cand_len;
                            aw_addr   <= cand_addr;
                            aw_len    <= 8'(cand_len - 9'd1);
                            aw_valid  <= 1'b1;
                            state     <= S_AW;
                        end
                    end
                end
                S_AW: begin
                    if (aw_hs) begin
                        aw_valid <= 1'b0;
                        beat_cnt <= '0;
                        w_last   <= (len == 9'd1);
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_hs) begin
                        if (w_last) begin
                            w_last  <= 1'b0;
                            b_ready <= 1'b1;
                            state   <= S_RESP;
                        end else begin
                            beat_cnt <= beat_cnt + 9'd1;
                            w_last   <= (beat_cnt + 9'd2 == len);
                        end
                    end
                end
                S_RESP: begin
                    if (b_hs) begin
                        b_ready   <= 1'b0;
                        addr      <= cand_addr;
                        remaining <= cand_rem;
                        if (B_RESP[1]) werror <= 1'b1;
                        if (cand_rem == '0) begin
                            wdone <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            len      <= cand_len;
                            aw_addr  <= cand_addr;
                            aw_len   <= 8'(cand_len - 9'd1);
                            aw_valid <= 1'b1;
                            state    <= S_AW;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
